// File: rtl/mem_dma_copy_if.sv
// -----------------------------------------------------------------------------
// mem_dma_copy_if
//   Bundles the request/acknowledge channels, the source read port, the
//   destination write port and the status outputs of mem_dma_copy.
//
//   Parameters: NCH (channels), AW (address/length width), DW (data width).
//
//   Signals:
//     dma_req_i / dma_ack_o        per-channel four-phase handshake
//     dma_src_addr_i, dma_dst_addr_i, dma_len_i
//                                  per-channel descriptors, channel c at [c*AW +: AW]
//     src_en_o, src_addr_o, src_dt_i   source memory read port
//     dst_wr_o, dst_addr_o, dst_dt_o   destination memory write port
//     busy_o, ch_sel_o             engine status
//
//   Optional macro MEM_DMA_FILL_EN adds dma_fill_i and dma_fill_dt_i
//   (per-channel fill flag and fill word, channel c at [c*DW +: DW]).
//
//   Modports: master = the DMA engine, slave = requesters plus memories.
// -----------------------------------------------------------------------------
interface mem_dma_copy_if #(
   parameter int NCH = 2,
   parameter int AW  = 8,
   parameter int DW  = 32
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]    dma_req_i;
   logic [NCH-1:0]    dma_ack_o;
   logic [NCH*AW-1:0] dma_src_addr_i;
   logic [NCH*AW-1:0] dma_dst_addr_i;
   logic [NCH*AW-1:0] dma_len_i;
`ifdef MEM_DMA_FILL_EN
   logic [NCH-1:0]    dma_fill_i;
   logic [NCH*DW-1:0] dma_fill_dt_i;
`endif
   logic              src_en_o;
   logic [AW-1:0]     src_addr_o;
   logic [DW-1:0]     src_dt_i;
   logic              dst_wr_o;
   logic [AW-1:0]     dst_addr_o;
   logic [DW-1:0]     dst_dt_o;
   logic              busy_o;
   logic [CW-1:0]     ch_sel_o;

   modport master (
`ifdef MEM_DMA_FILL_EN
      input  dma_fill_i, dma_fill_dt_i,
`endif
      input  dma_req_i, dma_src_addr_i, dma_dst_addr_i, dma_len_i, src_dt_i,
      output dma_ack_o, src_en_o, src_addr_o, dst_wr_o, dst_addr_o, dst_dt_o,
             busy_o, ch_sel_o
   );

   modport slave (
`ifdef MEM_DMA_FILL_EN
      output dma_fill_i, dma_fill_dt_i,
`endif
      output dma_req_i, dma_src_addr_i, dma_dst_addr_i, dma_len_i, src_dt_i,
      input  dma_ack_o, src_en_o, src_addr_o, dst_wr_o, dst_addr_o, dst_dt_o,
             busy_o, ch_sel_o
   );
endinterface

// File: rtl/mem_dma_copy.sv
// -----------------------------------------------------------------------------
// mem_dma_copy
//   Multi-channel memory-to-memory DMA copy engine. NCH requesters hand over
//   (src, dst, len) with a four-phase req/ack handshake; a round-robin arbiter
//   serves one channel at a time, streaming one word per cycle from the source
//   read port to the destination write port.
//
//   Ports:
//     ps_clk  clock
//     rst_i   asynchronous reset, active-high
//     bus     mem_dma_copy_if.master (handshake, descriptors, memory ports,
//             busy_o, ch_sel_o)
//
//   Parameters: NCH (1..8), AW, DW, RD_LAT (source read latency, 1 or 2).
//
//   Optional macro MEM_DMA_FILL_EN: a channel granted with dma_fill_i set
//   writes its fill word len times without touching the source port.
// -----------------------------------------------------------------------------
module mem_dma_copy #(
   parameter int NCH    = 2,
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic           ps_clk,
   input  logic           rst_i,
   mem_dma_copy_if.master bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   logic [1:0]        state;
   logic [CW-1:0]     ptr;
   logic [CW-1:0]     ch_sel;
   logic [NCH-1:0]    ack;
   logic [AW-1:0]     src_cur;
   logic [AW-1:0]     dst_cur;
   logic [AW-1:0]     rd_left;
   logic [AW-1:0]     wr_left;
   logic [RD_LAT-1:0] en_pipe;
   logic              src_en;
   logic              dst_wr;

   logic [NCH-1:0]    eligible;
   logic              gnt_vld;
   logic [CW-1:0]     gnt;
   logic [CW-1:0]     arb_idx;
   logic [AW-1:0]     gnt_src;
   logic [AW-1:0]     gnt_dst;
   logic [AW-1:0]     gnt_len;

`ifdef MEM_DMA_FILL_EN
   logic              fill_mode;
   logic [DW-1:0]     fill_word;
   logic              gnt_fill;
   logic [DW-1:0]     gnt_fword;
`endif

   // Round-robin pick: first eligible channel scanning upward from ptr with
   // wrap. A channel whose ack is still high is not eligible, so a requester
   // must complete the handshake before it can be served again.
   always_comb begin
      eligible = bus.dma_req_i & ~ack;
      gnt_vld  = 1'b0;
      gnt      = '0;
      arb_idx  = '0;
      for (int k = 0; k < NCH; k++) begin
         arb_idx = CW'((int'(ptr) + k) % NCH);
         if (!gnt_vld && eligible[arb_idx]) begin
            gnt_vld = 1'b1;
            gnt     = arb_idx;
         end
      end
      gnt_src = bus.dma_src_addr_i[int'(gnt)*AW +: AW];
      gnt_dst = bus.dma_dst_addr_i[int'(gnt)*AW +: AW];
      gnt_len = bus.dma_len_i[int'(gnt)*AW +: AW];
`ifdef MEM_DMA_FILL_EN
      gnt_fill  = bus.dma_fill_i[gnt];
      gnt_fword = bus.dma_fill_dt_i[int'(gnt)*DW +: DW];
`endif
   end

   // The write strobe is the read enable delayed by the memory latency, so
   // the returned word is forwarded in the cycle it appears. In fill mode the
   // source port stays idle and writes are issued straight from RUN.
`ifdef MEM_DMA_FILL_EN
   assign src_en       = (state == S_RUN) && !fill_mode;
   assign dst_wr       = fill_mode ? (state == S_RUN) : en_pipe[RD_LAT-1];
   assign bus.dst_dt_o = !dst_wr ? '0 : (fill_mode ? fill_word : bus.src_dt_i);
`else
   assign src_en       = (state == S_RUN);
   assign dst_wr       = en_pipe[RD_LAT-1];
   assign bus.dst_dt_o = dst_wr ? bus.src_dt_i : '0;
`endif

   assign bus.src_en_o   = src_en;
   assign bus.src_addr_o = src_cur;
   assign bus.dst_wr_o   = dst_wr;
   assign bus.dst_addr_o = dst_cur;
   assign bus.dma_ack_o  = ack;
   assign bus.busy_o     = (state != S_IDLE);
   assign bus.ch_sel_o   = ch_sel;

   // Control FSM plus read-to-write pipeline. A zero-length request passes
   // through DRAIN for one cycle with nothing outstanding, which makes its ack
   // rise on the edge after the grant without any memory access.
   always_ff @(posedge ps_clk or posedge rst_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         ptr       <= '0;
         ch_sel    <= '0;
         ack       <= '0;
         src_cur   <= '0;
         dst_cur   <= '0;
         rd_left   <= '0;
         wr_left   <= '0;
         en_pipe   <= '0;
`ifdef MEM_DMA_FILL_EN
         fill_mode <= 1'b0;
         fill_word <= '0;
`endif
      end else begin
         en_pipe[0] <= src_en;
         for (int i = 1; i < RD_LAT; i++) begin
            en_pipe[i] <= en_pipe[i-1];
         end
         if (dst_wr) begin
            dst_cur <= dst_cur + AW'(1);
            wr_left <= wr_left - AW'(1);
         end
         if (src_en) begin
            src_cur <= src_cur + AW'(1);
         end
         case (state)
            S_IDLE: begin
               if (gnt_vld) begin
                  ch_sel    <= gnt;
                  ptr       <= CW'((int'(gnt) + 1) % NCH);
                  src_cur   <= gnt_src;
                  dst_cur   <= gnt_dst;
                  rd_left   <= gnt_len;
                  wr_left   <= gnt_len;
`ifdef MEM_DMA_FILL_EN
                  fill_mode <= gnt_fill;
                  fill_word <= gnt_fword;
`endif
                  state     <= (gnt_len == '0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               rd_left <= rd_left - AW'(1);
               if (rd_left == AW'(1)) begin
`ifdef MEM_DMA_FILL_EN
                  if (fill_mode) begin
                     state       <= S_ACK;
                     ack[ch_sel] <= 1'b1;
                  end else
`endif
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((wr_left == '0) || (dst_wr && (wr_left == AW'(1)))) begin
                  state       <= S_ACK;
                  ack[ch_sel] <= 1'b1;
               end
            end
            default: begin
               if (!bus.dma_req_i[ch_sel]) begin
                  ack   <= '0;
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_dma_copy.sv
// -----------------------------------------------------------------------------
// tb_mem_dma_copy
//   Self-checking bench for mem_dma_copy. A source memory with RD_LAT read
//   latency answers the read port; each transfer is checked word by word
//   against a reference built from the copy rules (dst+i receives the word at
//   src+i, addresses wrapping), with ack timing and round-robin order predicted
//   from a model pointer. Directed cases are followed by randomized requests.
// -----------------------------------------------------------------------------
module tb_mem_dma_copy #(
   parameter int RD_LAT = 1
);
   localparam int NCH   = 2;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;
   localparam int AMASK = DEPTH - 1;

   logic ps_clk = 1'b0;
   logic rst_i  = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int model_ptr = 0;

   // Per-channel descriptors for the next request on that channel.
   int          c_src   [NCH];
   int          c_dst   [NCH];
   int          c_len   [NCH];
   int          c_hold  [NCH];
   bit          c_fill  [NCH];
   logic [31:0] c_fword [NCH];

   logic [DW-1:0] src_mem [DEPTH];
   logic [DW-1:0] rd_pipe [RD_LAT];

   mem_dma_copy_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

   mem_dma_copy #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .ps_clk (ps_clk),
      .rst_i  (rst_i),
      .bus    (bus)
   );

   always #5 ps_clk = ~ps_clk;

   // Source memory: data for an enabled read shows up RD_LAT cycles later.
   always @(posedge ps_clk) begin
      rd_pipe[0] <= bus.src_en_o ? src_mem[bus.src_addr_o] : '0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.src_dt_i = rd_pipe[RD_LAT-1];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic setChan(input int c, input int src, input int dst, input int len,
                          input int hold, input bit fill, input logic [31:0] fword);
      c_src[c] = src; c_dst[c] = dst; c_len[c] = len;
      c_hold[c] = hold; c_fill[c] = fill; c_fword[c] = fword;
   endtask

   task automatic driveChan(input int c);
      bus.dma_src_addr_i[c*AW +: AW] = AW'(c_src[c]);
      bus.dma_dst_addr_i[c*AW +: AW] = AW'(c_dst[c]);
      bus.dma_len_i[c*AW +: AW]      = AW'(c_len[c]);
`ifdef MEM_DMA_FILL_EN
      bus.dma_fill_i[c]              = c_fill[c];
      bus.dma_fill_dt_i[c*DW +: DW]  = c_fword[c];
`endif
   endtask

   // Round-robin rule: lowest pending channel at or after the pointer, wrapping.
   function automatic int pickNext(input int pending);
      for (int k = 0; k < NCH; k++) begin
         if (pending[(model_ptr + k) % NCH]) return (model_ptr + k) % NCH;
      end
      return 0;
   endfunction

   // Follows one granted transfer from the cycle after the grant edge (t=1)
   // until its ack rises, checking every read and write it issues.
   task automatic observeXfer(input int ch, input int drop_at);
      int t, t_ack, rd_n, wr_n, n, exp_ack;
      bit fl;
      logic [DW-1:0] exp_d;
      n = c_len[ch]; fl = c_fill[ch];
      t = 0; t_ack = -1; rd_n = 0; wr_n = 0;
      exp_ack = (n == 0) ? 2 : (fl ? 1 + n : 1 + n + RD_LAT);
      while (t_ack < 0 && t < n + RD_LAT + 30) begin
         @(negedge ps_clk);
         t++;
         if (t == drop_at) bus.dma_req_i[ch] = 1'b0;
         if (t == 1) checkOutput("busy_after_grant", bus.busy_o, 1);
         if (bus.src_en_o) begin
            if (rd_n == 0) checkOutput("first_rd_cycle", t, 1);
            checkOutput("rd_addr", bus.src_addr_o, (c_src[ch] + rd_n) & AMASK);
            rd_n++;
         end
         if (bus.dst_wr_o) begin
            exp_d = fl ? c_fword[ch] : src_mem[(c_src[ch] + wr_n) & AMASK];
            checkOutput("wr_addr", bus.dst_addr_o, (c_dst[ch] + wr_n) & AMASK);
            checkOutput("wr_data", bus.dst_dt_o, exp_d);
            wr_n++;
         end
         if (bus.dma_ack_o != '0) t_ack = t;
      end
      checkOutput("ack_cycle", t_ack, exp_ack);
      checkOutput("ack_vector", bus.dma_ack_o, 1 << ch);
      checkOutput("ch_sel", bus.ch_sel_o, ch);
      checkOutput("rd_count", rd_n, fl ? 0 : n);
      checkOutput("wr_count", wr_n, n);
   endtask

   // Completes the handshake: ack holds while req stays high and drops one
   // cycle after req is seen low; the engine is then back in IDLE.
   task automatic finishAck(input int ch);
      if (bus.dma_req_i[ch]) begin
         repeat (c_hold[ch]) begin
            @(negedge ps_clk);
            checkOutput("ack_hold", bus.dma_ack_o[ch], 1);
         end
         bus.dma_req_i[ch] = 1'b0;
      end
      @(negedge ps_clk);
      checkOutput("ack_drop", bus.dma_ack_o, 0);
      checkOutput("idle_after_ack", bus.busy_o, 0);
   endtask

   // Raises req on every channel in mask in the same cycle and follows the
   // transfers in the order the round-robin model predicts.
   task automatic applyStimulus(input int mask, input int drop_at);
      int pending, g;
      @(negedge ps_clk);
      for (int c = 0; c < NCH; c++) begin
         if (mask[c]) begin
            driveChan(c);
            bus.dma_req_i[c] = 1'b1;
         end
      end
      pending = mask;
      while (pending != 0) begin
         g = pickNext(pending);
         observeXfer(g, ($countones(mask) == 1) ? drop_at : -1);
         finishAck(g);
         pending &= ~(1 << g);
         model_ptr = (g + 1) % NCH;
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int mask, drop, seen, guard;
      for (int i = 0; i < DEPTH; i++) src_mem[i] = DW'(i) | ($urandom << 8);
      bus.dma_req_i      = '0;
      bus.dma_src_addr_i = '0;
      bus.dma_dst_addr_i = '0;
      bus.dma_len_i      = '0;
`ifdef MEM_DMA_FILL_EN
      bus.dma_fill_i     = '0;
      bus.dma_fill_dt_i  = '0;
`endif
      repeat (3) @(negedge ps_clk);
      checkOutput("rst_busy", bus.busy_o, 0);
      checkOutput("rst_ack", bus.dma_ack_o, 0);
      checkOutput("rst_src_en", bus.src_en_o, 0);
      checkOutput("rst_dst_wr", bus.dst_wr_o, 0);
      checkOutput("rst_ch_sel", bus.ch_sel_o, 0);
      rst_i = 1'b0;

      $display("[TB] basic copy ch0 0->10 len 10");
      setChan(0, 0, 10, 10, 2, 0, 0);
      applyStimulus(1, -1);

      $display("[TB] simultaneous requests, twice");
      setChan(0, 0, 20, 10, 0, 0, 0);
      setChan(1, 10, 40, 10, 1, 0, 0);
      applyStimulus(3, -1);
      setChan(0, 5, 60, 3, 0, 0, 0);
      applyStimulus(1, -1);
      setChan(0, 0, 20, 10, 0, 0, 0);
      applyStimulus(3, -1);

      $display("[TB] zero length on ch1");
      setChan(1, 33, 90, 0, 1, 0, 0);
      applyStimulus(2, -1);

      $display("[TB] address wrap 250->100 len 10");
      setChan(0, 250, 100, 10, 0, 0, 0);
      applyStimulus(1, -1);

      $display("[TB] req dropped mid-transfer");
      setChan(1, 40, 120, 10, 0, 0, 0);
      applyStimulus(2, 3);

`ifdef MEM_DMA_FILL_EN
      $display("[TB] fill 0xDEADBEEF len 5");
      setChan(0, 7, 180, 5, 0, 1, 32'hDEADBEEF);
      applyStimulus(1, -1);
`endif

      $display("[TB] reset during RUN");
      setChan(0, 30, 150, 10, 0, 0, 0);
      @(negedge ps_clk);
      driveChan(0);
      bus.dma_req_i[0] = 1'b1;
      seen = 0; guard = 0;
      while (seen < 5 && guard < 20) begin
         @(negedge ps_clk);
         guard++;
         if (bus.src_en_o) seen++;
      end
      checkOutput("pre_rst_word4", bus.src_addr_o, 34);
      #1 rst_i = 1'b1;
      #1;
      checkOutput("midrst_src_en", bus.src_en_o, 0);
      checkOutput("midrst_src_addr", bus.src_addr_o, 0);
      checkOutput("midrst_dst_wr", bus.dst_wr_o, 0);
      checkOutput("midrst_dst_addr", bus.dst_addr_o, 0);
      checkOutput("midrst_dst_dt", bus.dst_dt_o, 0);
      checkOutput("midrst_busy", bus.busy_o, 0);
      checkOutput("midrst_ack", bus.dma_ack_o, 0);
      @(negedge ps_clk);
      bus.dma_req_i = '0;
      rst_i = 1'b0;
      model_ptr = 0;
      setChan(1, 77, 200, 6, 1, 0, 0);
      applyStimulus(2, -1);

      $display("[TB] randomized requests");
      for (int it = 0; it < 60; it++) begin
         mask = int'($urandom_range(1, (1 << NCH) - 1));
         for (int c = 0; c < NCH; c++) begin
            setChan(c, int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 60))
                                                : int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 2)), 1'b0, $urandom);
`ifdef MEM_DMA_FILL_EN
            c_fill[c] = ($urandom_range(0, 3) == 0);
`endif
         end
         drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : -1;
         applyStimulus(mask, drop);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
